// File: rtl/aes_block_loader.sv
// rtl/aes_block_loader.sv - word-stream staging and multicycle capture around a combinational AES-128 core
//
// Assembles a 32-bit word stream into the 128-bit key and plaintext registers that feed a
// combinational AES-128 encrypt core. After the last plaintext word it waits WAIT_CYCLES edges
// for the core path to settle, then captures the ciphertext and offers it on a valid/ready port.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               synchronous abort back to key loading, partial block discarded
//   in_data/in_valid    32-bit key/plaintext words, MS word first
//   in_ready            high while loading key or plaintext (decoded from registered state)
//   core_key, core_in   registered key and plaintext driven into the encrypt core
//   core_out            ciphertext returned by the encrypt core
//   out_data/out_valid  captured ciphertext, held until out_ready
//   out_ready           downstream accepts out_data
//   busy                high while waiting for the core or presenting the result
//
// Parameter WAIT_CYCLES (1..15): edges from the last accepted plaintext word to out_valid.
// Optional feature AES_KEY_HOLD_EN: once a key is loaded, later blocks carry plaintext only and
// reuse core_key; flush or reset forces a fresh key load.

module aes_block_loader #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] core_key,
  output logic [127:0] core_in,
  input  logic [127:0] core_out,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_LOAD_KEY = 2'd0,
    ST_LOAD_PT  = 2'd1,
    ST_WAIT     = 2'd2,
    ST_OUT      = 2'd3
  } state_t;

  // Counter reload so that the capture happens on the WAIT_CYCLES-th edge after the last word.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

`ifdef AES_KEY_HOLD_EN
  localparam state_t AFTER_OUT = ST_LOAD_PT;
`else
  localparam state_t AFTER_OUT = ST_LOAD_KEY;
`endif

  state_t     state;
  logic [1:0] idx;
  logic [3:0] wait_cnt;
  logic       xfer;
  logic [6:0] lane_lsb;

  assign in_ready = (state == ST_LOAD_KEY) || (state == ST_LOAD_PT);
  assign xfer     = in_valid && in_ready;

  // Word k lands in bits [127-32k : 96-32k]; (3-k)*32 equals {~k, 5'b0} for a 2-bit k.
  assign lane_lsb = {~idx, 5'b00000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOAD_KEY;
      idx       <= 2'd0;
      wait_cnt  <= 4'd0;
      core_key  <= '0;
      core_in   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (flush) begin
      // Abort wins over any transfer or handshake in the same cycle; data registers keep their values.
      state     <= ST_LOAD_KEY;
      idx       <= 2'd0;
      wait_cnt  <= 4'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_LOAD_KEY: begin
          if (xfer) begin
            core_key[lane_lsb +: 32] <= in_data;
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              state <= ST_LOAD_PT;
            end
          end
        end
        ST_LOAD_PT: begin
          if (xfer) begin
            core_in[lane_lsb +: 32] <= in_data;
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_LOAD;
              busy     <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            out_data  <= core_out;
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_OUT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= AFTER_OUT;
          end
        end
        default: begin
          state <= ST_LOAD_KEY;
        end
      endcase
    end
  end

endmodule
